// File: rtl/mem_xlate_pkg.sv
// Shared constants for the load/store translation and issue unit:
// exception codes, direct-map window field layout, access sizes, page size.
package mem_xlate_pkg;

    typedef enum logic [2:0] {
        EXC_NONE = 3'd0,
        EXC_ALE  = 3'd1,
        EXC_TLBR = 3'd2,
        EXC_PIL  = 3'd3,
        EXC_PIS  = 3'd4,
        EXC_PPI  = 3'd5,
        EXC_PME  = 3'd6
    } exc_code_e;

    // Layout of one direct-map window byte: {plv0, plv3, pseg[2:0], vseg[2:0]}
    localparam int DMW_VSEG_LSB = 0;
    localparam int DMW_PSEG_LSB = 3;
    localparam int DMW_PLV3_BIT = 6;
    localparam int DMW_PLV0_BIT = 7;

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;

    localparam logic [5:0] PS_4M = 6'd22;

    // Byte strobes for a store of the given size at the given low address bits.
    function automatic logic [3:0] store_strb(input logic [1:0] size, input logic [1:0] lo);
        logic [3:0] strb;
        case (size)
            SZ_BYTE: strb = 4'b0001 << lo;
            SZ_HALF: strb = lo[1] ? 4'b1100 : 4'b0011;
            default: strb = 4'b1111;
        endcase
        return strb;
    endfunction

endpackage

// File: rtl/dmw_match.sv
// One direct-map window: hit detection against the current privilege level
// and the physical address the window would produce.
module dmw_match
    import mem_xlate_pkg::*;
(
    input  logic [7:0]  i_cfg,
    input  logic [31:0] i_va,
    input  logic [1:0]  i_plv,
    output logic        o_hit,
    output logic [31:0] o_pa
);

    logic [2:0] w_vseg;
    logic [2:0] w_pseg;
    logic       w_plv_ok;

    assign w_vseg   = i_cfg[DMW_VSEG_LSB +: 3];
    assign w_pseg   = i_cfg[DMW_PSEG_LSB +: 3];
    assign w_plv_ok = ((i_plv == 2'd0) & i_cfg[DMW_PLV0_BIT]) |
                      ((i_plv == 2'd3) & i_cfg[DMW_PLV3_BIT]);

    assign o_hit = (i_va[31:29] == w_vseg) & w_plv_ok;
    assign o_pa  = {w_pseg, i_va[28:0]};

endmodule

// File: rtl/mem_xlate_issue.sv
// EXE-stage load/store address translation and data-SRAM request issue.
// A single request slot is translated (direct, direct-map window or TLB),
// checked for ALE/TLB exceptions and issued on the req/addr_ok/data_ok bus.
// Responses belonging to requests that were in flight at a flush are dropped.
// Optional MEM_XLATE_PERF_EN adds TLB-issue and exception event counters.
module mem_xlate_issue
    import mem_xlate_pkg::*;
#(
    parameter int NUM_DMW   = 2,
    parameter int MAX_OUTST = 4,
    parameter int CNT_W     = 3
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [31:0]          in_vaddr,
    input  logic                 in_wr,
    input  logic [1:0]           in_size,
    input  logic [31:0]          in_wdata,
    input  logic                 flush,
    input  logic                 csr_da,
    input  logic [1:0]           csr_plv,
    input  logic [NUM_DMW*8-1:0] dmw_cfg,
    output logic [18:0]          tlb_vppn,
    output logic                 tlb_va_bit12,
    input  logic                 tlb_found,
    input  logic                 tlb_v,
    input  logic                 tlb_d,
    input  logic [19:0]          tlb_ppn,
    input  logic [5:0]           tlb_ps,
    input  logic [1:0]           tlb_plv,
    output logic                 sram_req,
    output logic                 sram_wr,
    output logic [1:0]           sram_size,
    output logic [3:0]           sram_wstrb,
    output logic [31:0]          sram_addr,
    output logic [31:0]          sram_wdata,
    input  logic                 sram_addr_ok,
    input  logic                 sram_data_ok,
    output logic                 resp_valid,
    output logic                 ex_valid,
    output logic [2:0]           ex_code,
    output logic [31:0]          ex_badv,
    output logic [CNT_W-1:0]     outst_cnt
`ifdef MEM_XLATE_PERF_EN
    ,
    output logic [31:0]          perf_tlb_cnt,
    output logic [31:0]          perf_exc_cnt
`endif
);

    logic             r_slot_valid;
    logic             r_first;
    logic             r_wr;
    logic [1:0]       r_size;
    logic [31:0]      r_vaddr;
    logic [31:0]      r_wdata;
    logic [CNT_W-1:0] r_outst;
    logic [CNT_W-1:0] r_discard;

    logic [NUM_DMW-1:0] w_dmw_hit;
    logic [31:0]        w_dmw_pa [NUM_DMW];
    logic [31:0]        w_dmw_sel_pa;
    logic               w_use_tlb;
    logic [31:0]        w_pa;
    logic               w_ale;
    exc_code_e          w_exc_code;
    logic               w_exc;
    logic               w_req;
    logic               w_issue;
    logic               w_dec;
    logic               w_accept;
    logic [3:0]         w_strb;
    logic [31:0]        w_wdata_rep;

    for (genvar g = 0; g < NUM_DMW; g++) begin : g_dmw
        dmw_match u_dmw (
            .i_cfg (dmw_cfg[g*8 +: 8]),
            .i_va  (r_vaddr),
            .i_plv (csr_plv),
            .o_hit (w_dmw_hit[g]),
            .o_pa  (w_dmw_pa[g])
        );
    end

    // Lowest-index window wins: scan downward so the lowest hit is written last.
    always_comb begin
        w_dmw_sel_pa = w_dmw_pa[0];
        for (int i = NUM_DMW - 1; i >= 0; i--) begin
            if (w_dmw_hit[i]) w_dmw_sel_pa = w_dmw_pa[i];
        end
    end

    // Address translation from the slot: direct, then windows, then TLB.
    always_comb begin
        w_use_tlb = 1'b0;
        w_pa      = r_vaddr;
        if (!csr_da) begin
            if (|w_dmw_hit) begin
                w_pa = w_dmw_sel_pa;
            end else begin
                w_use_tlb = 1'b1;
                w_pa      = (tlb_ps == PS_4M) ? {tlb_ppn[19:10], r_vaddr[21:0]}
                                              : {tlb_ppn, r_vaddr[11:0]};
            end
        end
    end

    // Exception classification in priority order.
    always_comb begin
        w_ale      = ((r_size == SZ_HALF) & r_vaddr[0]) |
                     ((r_size == SZ_WORD) & (r_vaddr[1:0] != 2'b00));
        w_exc_code = EXC_NONE;
        if (w_ale)                       w_exc_code = EXC_ALE;
        else if (w_use_tlb) begin
            if (!tlb_found)              w_exc_code = EXC_TLBR;
            else if (!tlb_v)             w_exc_code = r_wr ? EXC_PIS : EXC_PIL;
            else if (csr_plv > tlb_plv)  w_exc_code = EXC_PPI;
            else if (r_wr && !tlb_d)     w_exc_code = EXC_PME;
        end
    end

    // Exceptions are only judged in the slot's first cycle; later cycles are
    // waiting for addr_ok and must not re-fault on changing TLB inputs.
    assign w_exc    = r_slot_valid & r_first & (w_exc_code != EXC_NONE) & ~flush;
    assign w_req    = r_slot_valid & ~w_exc & ~flush & (r_outst < CNT_W'(MAX_OUTST));
    assign w_issue  = w_req & sram_addr_ok;
    assign w_dec    = sram_data_ok & (r_outst != '0);
    assign in_ready = ~r_slot_valid | w_issue | w_exc;
    assign w_accept = in_valid & in_ready & ~flush;

    // Store strobes and lane replication of the unaligned store data.
    always_comb begin
        w_strb      = r_wr ? store_strb(r_size, r_vaddr[1:0]) : 4'b0000;
        w_wdata_rep = r_wdata;
        case (r_size)
            SZ_BYTE: w_wdata_rep = {4{r_wdata[7:0]}};
            SZ_HALF: w_wdata_rep = {2{r_wdata[15:0]}};
            default: w_wdata_rep = r_wdata;
        endcase
    end

    assign tlb_vppn     = r_vaddr[31:13];
    assign tlb_va_bit12 = r_vaddr[12];

    // Request fields are a function of the held slot, so they stay stable
    // while req waits for addr_ok; they read as zero when no request is up.
    assign sram_req   = w_req;
    assign sram_wr    = w_req & r_wr;
    assign sram_size  = w_req ? r_size      : 2'b00;
    assign sram_wstrb = w_req ? w_strb      : 4'b0000;
    assign sram_addr  = w_req ? w_pa        : 32'd0;
    assign sram_wdata = w_req ? w_wdata_rep : 32'd0;

    assign ex_valid   = w_exc;
    assign ex_code    = w_exc ? w_exc_code : EXC_NONE;
    assign ex_badv    = w_exc ? r_vaddr : 32'd0;
    assign resp_valid = w_dec & (r_discard == '0) & ~flush;
    assign outst_cnt  = r_outst;

    // Request slot: load on accept, empty on issue, exception or flush.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_slot_valid <= 1'b0;
            r_first      <= 1'b0;
            r_wr         <= 1'b0;
            r_size       <= 2'b00;
            r_vaddr      <= 32'd0;
            r_wdata      <= 32'd0;
        end else begin
            r_first <= w_accept;
            if (w_accept) begin
                r_slot_valid <= 1'b1;
                r_wr         <= in_wr;
                r_size       <= in_size;
                r_vaddr      <= in_vaddr;
                r_wdata      <= in_wdata;
            end else if (flush | w_issue | w_exc) begin
                r_slot_valid <= 1'b0;
            end
        end
    end

    // Outstanding and discard accounting; a flush marks every in-flight
    // request (minus one answered this cycle) as stale.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_outst   <= '0;
            r_discard <= '0;
        end else begin
            case ({w_issue, w_dec})
                2'b10:   r_outst <= r_outst + CNT_W'(1);
                2'b01:   r_outst <= r_outst - CNT_W'(1);
                default: r_outst <= r_outst;
            endcase
            if (flush)
                r_discard <= r_outst - CNT_W'(w_dec);
            else if (w_dec && (r_discard != '0))
                r_discard <= r_discard - CNT_W'(1);
        end
    end

`ifdef MEM_XLATE_PERF_EN
    // Event counters: TLB-translated issues and exception pulses.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            perf_tlb_cnt <= 32'd0;
            perf_exc_cnt <= 32'd0;
        end else begin
            if (w_issue && w_use_tlb) perf_tlb_cnt <= perf_tlb_cnt + 32'd1;
            if (w_exc)                perf_exc_cnt <= perf_exc_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: doc/mem_xlate_issue.md
Name: mem_xlate_issue

Overview:
- Load/store address-translation and request-issue unit for the EXE stage of the pipeline.
- Accepts one memory operation per handshake and latches it into a single request slot.
- Translates the address by direct addressing, by NUM_DMW direct-map windows, or by the TLB port.
- Detects ALE and TLB exceptions, then drives the data-SRAM req/addr_ok/data_ok interface.
- Tracks up to MAX_OUTST outstanding accesses and discards responses belonging to flushed requests.

Parameters:
- NUM_DMW, 2, number of direct-map windows (1..4).
- MAX_OUTST, 4, maximum accepted-but-unanswered SRAM requests (power of 2, >=2).
- CNT_W, 3, width of outstanding/discard counters; must satisfy 2^CNT_W > MAX_OUTST.

Ports:
- clk  in  1  clock; all state updates on posedge.
- resetn  in  1  asynchronous active-low reset.
- in_valid  in  1  operation offered by EXE.
- in_ready  out  1  slot empty, or slot completing this cycle.
- in_vaddr  in  32  virtual address.
- in_wr  in  1  1=store, 0=load.
- in_size  in  2  0=byte, 1=half, 2=word.
- in_wdata  in  32  store data, unaligned (lane replication done here).
- flush  in  1  WB exception/ertn; cancels the slot.
- csr_da  in  1  CRMD.DA direct addressing.
- csr_plv  in  2  current privilege level.
- dmw_cfg  in  NUM_DMW*8  per window {plv0, plv3, pseg[2:0], vseg[2:0]}; window 0 in low byte.
- tlb_vppn  out  19  slot vaddr[31:13].
- tlb_va_bit12  out  1  slot vaddr[12].
- tlb_found, tlb_v, tlb_d  in  1 each  TLB lookup result.
- tlb_ppn  in  20  physical page number.
- tlb_ps  in  6  page size (12 or 22).
- tlb_plv  in  2  page privilege.
- sram_req  out  1  request valid.
- sram_wr  out  1  write.
- sram_size  out  2  access size.
- sram_wstrb  out  4  byte strobes.
- sram_addr  out  32  physical address.
- sram_wdata  out  32  lane-replicated data.
- sram_addr_ok  in  1  request accepted.
- sram_data_ok  in  1  response returned.
- resp_valid  out  1  data_ok for a non-discarded request.
- ex_valid  out  1  one-cycle exception pulse.
- ex_code  out  3  exception code.
- ex_badv  out  32  faulting vaddr.
- outst_cnt  out  CNT_W  current outstanding count.

Behaviour:
- Reset (async): slot empty, both counters 0. All outputs 0 except in_ready=1.
- Acceptance: in_valid&in_ready&~flush loads the slot; latency to first possible sram_req is 1 cycle.
- Translation (combinational from slot register), in priority order:
  - csr_da: pa=va.
  - Else the lowest-index DMW hit: va[31:29]==vseg and (plv==0&plv0 | plv==3&plv3); pa={pseg,va[28:0]}.
  - Else TLB: ps==22 gives {ppn[19:10],va[21:0]}; otherwise {ppn,va[11:0]}.
- Exceptions, evaluated in the first slot cycle, in priority order:
  - 1 ALE: half with va[0]; word with va[1:0]!=0.
  - 2 TLBR: TLB path and ~found.
  - 3 PIL / 4 PIS: ~v, load/store respectively.
  - 5 PPI: plv>tlb_plv.
  - 6 PME: store and ~d.
  - Code 0 = none. On an exception: ex_valid pulses one cycle with ex_code and ex_badv, no sram_req is issued, and the slot empties.
- Issue:
  - sram_req = slot_valid & ~exc & ~flush & (outst_cnt<MAX_OUTST).
  - sram_addr, sram_wr, sram_size, sram_wstrb and sram_wdata stay stable while req is held without addr_ok.
  - The slot empties on req&addr_ok.
  - in_ready = ~slot_valid | (sram_req&sram_addr_ok) | exc.
- Strobes by address low bits: byte 0001<<va[1:0]; half 0011 or 1100 by va[1]; word 1111. Loads use 0000.
- Outstanding counter: +1 on req&addr_ok, -1 on data_ok, unchanged if both occur in the same cycle. It never exceeds MAX_OUTST.
- Flush:
  - Empties the slot the same cycle and suppresses sram_req and ex_valid.
  - Loads discard_cnt with outst_cnt (accounting for any data_ok in the same cycle).
  - While discard_cnt>0, each data_ok decrements discard_cnt and resp_valid stays 0.
  - Flush while discard_cnt>0 reloads discard_cnt with the full outst_cnt.
- A data_ok while outst_cnt==0 is a protocol error and is ignored.

Optional Feature:
- MEM_XLATE_PERF_EN defined: adds outputs perf_tlb_cnt[31:0] (issued requests translated via TLB) and perf_exc_cnt[31:0] (ex_valid pulses). Both are wrapping counters, cleared by reset.
- Undefined: these ports and counters do not exist.

Decomposition:
- Package mem_xlate_pkg holds:
  - exception code constants EXC_NONE..EXC_PME;
  - the DMW field offsets within a byte;
  - the size encodings;
  - the PS_4M constant (22).
- Sub-module dmw_match (one instance per window, via generate): produces hit and pa for that window.

Test Plan:
- csr_da=0, plv=0, dmw0={plv0=1,pseg=0,vseg=5}, ld.w va=0xA000_1000 -> sram_addr=0x0000_1000, wstrb=0000, req 1 cycle after accept.
- st.b va=0x1C00_0003 with TLB ppn=0x12345, ps=12, v=d=1, wdata=0xAB -> addr=0x1234_5003, wstrb=1000, wdata=0xABABABAB.
- ld.h va=0x...1 -> ex_valid=1, ex_code=1, ex_badv=va, no sram_req. Store with found=1, v=1, d=0, plv ok -> ex_code=6.
- addr_ok held 0 for 3 cycles -> addr/wstrb stable, in_ready=0. Then 4 back-to-back accepts without data_ok -> 5th stalls, outst_cnt=4.
- 3 outstanding, then flush -> next 3 data_ok give resp_valid=0. Fourth (post-flush request) gives resp_valid=1.
- Assert resetn=0 mid-request -> outputs clear immediately without a clock edge; after release, outst_cnt=0 and in_ready=1.
